// File: rtl/issue_stage_if.sv
// Bundle of the decode-side, register-file and execute-side signals of the issue stage.
// The stage itself connects through the slave modport; the surrounding pipeline uses master.
interface issue_stage_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 8
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_op;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic            in_rs1_en;
  logic [4:0]      in_rs1;
  logic            in_rs2_en;
  logic [4:0]      in_rs2;
  logic            in_rd_en;
  logic [4:0]      in_rd;
  logic            rf_r0_valid;
  logic [4:0]      rf_r0_ad;
  logic            rf_r1_valid;
  logic [4:0]      rf_r1_ad;
  logic [XLEN-1:0] rf_r0_data;
  logic [XLEN-1:0] rf_r1_data;
  logic            rf_r_v;
  logic            rf_block_rd;
  logic [4:0]      rf_rd;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  out_op;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic            out_rd_en;
  logic [4:0]      out_rd;
  logic [31:0]     stall_cnt;
  logic            dbg_state;

  modport slave (
    input  flush, in_valid, in_op, in_pc, in_imm, in_use_imm,
           in_rs1_en, in_rs1, in_rs2_en, in_rs2, in_rd_en, in_rd,
           rf_r0_data, rf_r1_data, rf_r_v, out_ready,
    output in_ready, rf_r0_valid, rf_r0_ad, rf_r1_valid, rf_r1_ad,
           rf_block_rd, rf_rd, out_valid, out_op, out_pc, out_a, out_b,
           out_rd_en, out_rd, stall_cnt, dbg_state
  );

  modport master (
    output flush, in_valid, in_op, in_pc, in_imm, in_use_imm,
           in_rs1_en, in_rs1, in_rs2_en, in_rs2, in_rd_en, in_rd,
           rf_r0_data, rf_r1_data, rf_r_v, out_ready,
    input  in_ready, rf_r0_valid, rf_r0_ad, rf_r1_valid, rf_r1_ad,
           rf_block_rd, rf_rd, out_valid, out_op, out_pc, out_a, out_b,
           out_rd_en, out_rd, stall_cnt, dbg_state
  );
endinterface

// File: rtl/issue_stage.sv
// Single-entry issue stage: holds one decoded instruction, reads operands once the
// register file reports them not busy, and hands them to execute through a registered slot.
module issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 8
) (
  input logic         clk,
  input logic         rst,
  issue_stage_if.slave io
);
  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // valid never depends combinationally on ready, and out_* are held while out_valid & ~out_ready.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [OPW-1:0]  h_op;
  logic [XLEN-1:0] h_pc;
  logic [XLEN-1:0] h_imm;
  logic            h_use_imm;
  logic            h_rs1_en;
  logic [4:0]      h_rs1;
  logic            h_rs2_en;
  logic [4:0]      h_rs2;
  logic            h_rd_en;
  logic [4:0]      h_rd;

  logic slot_free;
  logic issue;
  logic accept;

  assign slot_free    = ~io.out_valid | io.out_ready;
  assign issue        = (state == S_WAIT) & io.rf_r_v & slot_free & ~io.flush;
  assign accept       = io.in_valid & io.in_ready;
  assign io.dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (io.flush)  state_nxt = S_IDLE;
    else if (accept) state_nxt = S_WAIT;
    else if (issue)  state_nxt = S_IDLE;
  end

  // Output logic: read ports only reflect the hold register while it is full
  always_comb begin
    io.in_ready    = ((state == S_IDLE) | issue) & ~io.flush & ~rst;
    io.rf_r0_valid = 1'b0;
    io.rf_r0_ad    = '0;
    io.rf_r1_valid = 1'b0;
    io.rf_r1_ad    = '0;
    io.rf_block_rd = issue & h_rd_en & (h_rd != 5'd0);
    io.rf_rd       = h_rd;
    if (state == S_WAIT) begin
      io.rf_r0_valid = h_rs1_en;
      io.rf_r0_ad    = h_rs1;
      io.rf_r1_valid = h_rs2_en & ~h_use_imm;
      io.rf_r1_ad    = h_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_op      <= '0;
      h_pc      <= '0;
      h_imm     <= '0;
      h_use_imm <= 1'b0;
      h_rs1_en  <= 1'b0;
      h_rs1     <= '0;
      h_rs2_en  <= 1'b0;
      h_rs2     <= '0;
      h_rd_en   <= 1'b0;
      h_rd      <= '0;
    end else if (io.flush) begin
      h_op      <= '0;
      h_pc      <= '0;
      h_imm     <= '0;
      h_use_imm <= 1'b0;
      h_rs1_en  <= 1'b0;
      h_rs1     <= '0;
      h_rs2_en  <= 1'b0;
      h_rs2     <= '0;
      h_rd_en   <= 1'b0;
      h_rd      <= '0;
    end else if (accept) begin
      h_op      <= io.in_op;
      h_pc      <= io.in_pc;
      h_imm     <= io.in_imm;
      h_use_imm <= io.in_use_imm;
      h_rs1_en  <= io.in_rs1_en;
      h_rs1     <= io.in_rs1;
      h_rs2_en  <= io.in_rs2_en;
      h_rs2     <= io.in_rs2;
      h_rd_en   <= io.in_rd_en;
      h_rd      <= io.in_rd;
    end
  end

  // Output slot; x0 always reads as zero regardless of what the register file returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.out_valid <= 1'b0;
      io.out_op    <= '0;
      io.out_pc    <= '0;
      io.out_a     <= '0;
      io.out_b     <= '0;
      io.out_rd_en <= 1'b0;
      io.out_rd    <= '0;
    end else if (io.flush) begin
      io.out_valid <= 1'b0;
    end else if (issue) begin
      io.out_valid <= 1'b1;
      io.out_op    <= h_op;
      io.out_pc    <= h_pc;
      io.out_a     <= (h_rs1_en && h_rs1 != 5'd0) ? io.rf_r0_data : '0;
      io.out_b     <= h_use_imm ? h_imm :
                      ((h_rs2_en && h_rs2 != 5'd0) ? io.rf_r1_data : '0);
      io.out_rd_en <= h_rd_en;
      io.out_rd    <= h_rd;
    end else if (io.out_valid & io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end

  // Only operand-not-ready waits are counted; a full output slot is back-pressure, not a hazard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) io.stall_cnt <= '0;
    else if ((state == S_WAIT) && !io.rf_r_v && !io.flush && (io.stall_cnt != 32'hFFFF_FFFF))
      io.stall_cnt <= io.stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: hand-computed expectations checked with immediate assertions.
module tb_issue_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  issue_stage_if #(.XLEN(32), .OPW(8)) io ();

  issue_stage #(.XLEN(32), .OPW(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic rs1_en, input logic [4:0] rs1,
                       input logic rs2_en, input logic [4:0] rs2, input logic use_imm,
                       input logic [31:0] imm, input logic rd_en, input logic [4:0] rd);
    io.in_valid   = 1'b1;
    io.in_op      = pc[7:0];
    io.in_pc      = pc;
    io.in_rs1_en  = rs1_en;
    io.in_rs1     = rs1;
    io.in_rs2_en  = rs2_en;
    io.in_rs2     = rs2;
    io.in_use_imm = use_imm;
    io.in_imm     = imm;
    io.in_rd_en   = rd_en;
    io.in_rd      = rd;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    io.flush = 1'b0;
    io.in_valid = 1'b0;
    io.in_op = '0;
    io.in_pc = '0;
    io.in_imm = '0;
    io.in_use_imm = 1'b0;
    io.in_rs1_en = 1'b0;
    io.in_rs1 = '0;
    io.in_rs2_en = 1'b0;
    io.in_rs2 = '0;
    io.in_rd_en = 1'b0;
    io.in_rd = '0;
    io.rf_r0_data = '0;
    io.rf_r1_data = '0;
    io.rf_r_v = 1'b0;
    io.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_stall_cnt", io.stall_cnt, 0);
    chk("rst_block_rd", io.rf_block_rd, 0);
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_out_a", io.out_a, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", io.in_ready, 1);
    chk("idle_r0_valid", io.rf_r0_valid, 0);

    // Basic issue: rs1=1, rs2=2, rd=3
    io.rf_r_v = 1'b1;
    io.rf_r0_data = 32'h11;
    io.rf_r1_data = 32'h22;
    drive(32'h100, 1, 5'd1, 1, 5'd2, 0, 32'h0, 1, 5'd3);
    tick();
    io.in_valid = 1'b0;
    #1;
    chk("t1_state_wait", io.dbg_state, 1);
    chk("t1_r0_valid", io.rf_r0_valid, 1);
    chk("t1_r0_ad", io.rf_r0_ad, 1);
    chk("t1_r1_valid", io.rf_r1_valid, 1);
    chk("t1_r1_ad", io.rf_r1_ad, 2);
    chk("t1_block_rd", io.rf_block_rd, 1);
    chk("t1_rf_rd", io.rf_rd, 3);
    chk("t1_out_valid_early", io.out_valid, 0);
    tick();
    chk("t1_out_valid", io.out_valid, 1);
    chk("t1_out_a", io.out_a, 32'h11);
    chk("t1_out_b", io.out_b, 32'h22);
    chk("t1_out_pc", io.out_pc, 32'h100);
    chk("t1_out_rd", io.out_rd, 3);
    chk("t1_block_rd_once", io.rf_block_rd, 0);
    tick();
    chk("t1_out_drain", io.out_valid, 0);

    // x0 source, immediate operand, rd=0
    io.rf_r0_data = 32'hDEAD;
    drive(32'h200, 1, 5'd0, 1, 5'd5, 1, 32'h7, 1, 5'd0);
    tick();
    io.in_valid = 1'b0;
    #1;
    chk("t2_r0_valid", io.rf_r0_valid, 1);
    chk("t2_r1_valid", io.rf_r1_valid, 0);
    chk("t2_block_rd", io.rf_block_rd, 0);
    tick();
    chk("t2_out_valid", io.out_valid, 1);
    chk("t2_out_a", io.out_a, 0);
    chk("t2_out_b", io.out_b, 32'h7);
    tick();

    // Operand hazard stall for 5 cycles
    io.rf_r_v = 1'b0;
    io.rf_r0_data = 32'h44;
    drive(32'h300, 1, 5'd4, 0, 5'd0, 0, 32'h0, 1, 5'd6);
    tick();
    io.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_in_ready", io.in_ready, 0);
      chk("t3_out_valid", io.out_valid, 0);
    end
    chk("t3_stall_cnt", io.stall_cnt, 5);
    io.rf_r_v = 1'b1;
    #1;
    chk("t3_release_block", io.rf_block_rd, 1);
    chk("t3_release_rd", io.rf_rd, 6);
    tick();
    chk("t3_out_valid", io.out_valid, 1);
    chk("t3_out_pc", io.out_pc, 32'h300);
    chk("t3_out_a", io.out_a, 32'h44);
    chk("t3_stall_hold", io.stall_cnt, 5);
    tick();

    // Back-pressure with two queued instructions
    io.out_ready = 1'b0;
    drive(32'h400, 1, 5'd1, 0, 5'd0, 0, 32'h0, 1, 5'd7);
    tick();
    drive(32'h404, 1, 5'd2, 0, 5'd0, 0, 32'h0, 1, 5'd8);
    #1;
    chk("t4_a_block", io.rf_block_rd, 1);
    chk("t4_a_rd", io.rf_rd, 7);
    chk("t4_b_ready", io.in_ready, 1);
    tick();
    io.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_out_valid", io.out_valid, 1);
      chk("t4_out_pc", io.out_pc, 32'h400);
      chk("t4_out_rd", io.out_rd, 7);
      chk("t4_no_block", io.rf_block_rd, 0);
      chk("t4_in_ready", io.in_ready, 0);
      chk("t4_stall_cnt", io.stall_cnt, 5);
      tick();
    end
    io.out_ready = 1'b1;
    #1;
    chk("t4_b_block", io.rf_block_rd, 1);
    chk("t4_b_rd", io.rf_rd, 8);
    tick();
    chk("t4_b_out_pc", io.out_pc, 32'h404);
    chk("t4_b_out_valid", io.out_valid, 1);
    tick();
    chk("t4_drain", io.out_valid, 0);

    // Stream of 4 independent instructions
    drive(32'h500, 1, 5'd9, 0, 5'd0, 0, 32'h0, 0, 5'd0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(32'h500 + 32'(4 * i), 1, 5'd9, 0, 5'd0, 0, 32'h0, 0, 5'd0);
      #1;
      chk("t5_in_ready", io.in_ready, 1);
      tick();
      chk("t5_out_valid", io.out_valid, 1);
      chk("t5_out_pc", io.out_pc, 32'h500 + 32'(4 * (i - 1)));
    end
    io.in_valid = 1'b0;
    tick();
    chk("t5_last_valid", io.out_valid, 1);
    chk("t5_last_pc", io.out_pc, 32'h50C);
    tick();
    chk("t5_drain", io.out_valid, 0);

    // Flush while WAIT and out_valid=1
    drive(32'h600, 1, 5'd1, 0, 5'd0, 0, 32'h0, 1, 5'd10);
    tick();
    drive(32'h604, 1, 5'd1, 0, 5'd0, 0, 32'h0, 1, 5'd11);
    tick();
    chk("t6_pre_valid", io.out_valid, 1);
    chk("t6_pre_state", io.dbg_state, 1);
    io.flush = 1'b1;
    drive(32'h608, 1, 5'd1, 0, 5'd0, 0, 32'h0, 1, 5'd12);
    #1;
    chk("t6_flush_in_ready", io.in_ready, 0);
    chk("t6_flush_block", io.rf_block_rd, 0);
    tick();
    io.flush = 1'b0;
    io.in_valid = 1'b0;
    #1;
    chk("t6_out_valid", io.out_valid, 0);
    chk("t6_in_ready", io.in_ready, 1);
    chk("t6_r0_valid", io.rf_r0_valid, 0);
    chk("t6_stall_kept", io.stall_cnt, 5);

    // Asynchronous reset mid-WAIT
    io.rf_r_v = 1'b0;
    drive(32'h700, 1, 5'd3, 0, 5'd0, 0, 32'h0, 1, 5'd13);
    tick();
    io.in_valid = 1'b0;
    #1;
    chk("t7_wait_r0", io.rf_r0_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_r0", io.rf_r0_valid, 0);
    chk("t7_rst_stall", io.stall_cnt, 0);
    chk("t7_rst_block", io.rf_block_rd, 0);
    chk("t7_rst_in_ready", io.in_ready, 0);
    chk("t7_rst_out_pc", io.out_pc, 0);
    tick();
    rst = 1'b0;
    io.rf_r_v = 1'b1;
    #1;
    chk("t7_post_idle", io.dbg_state, 0);
    chk("t7_post_block", io.rf_block_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Single-entry issue stage between decode and execute.
- Holds one decoded instruction and drives the register file read ports for rs1/rs2.
- Waits for the register file's operand-ready flag (r_v); on issue, marks rd busy via block_rd.
- Presents operands to execute through a registered valid/ready output slot.
- Sustains one instruction per cycle when no hazards are present.

Parameters:
- XLEN, 32, data/operand width
- OPW, 8, width of opaque opcode/control bundle passed through to execute

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard held and output instructions (branch redirect)
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept instruction this cycle
- in_op  in  OPW  opcode/control bundle
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  immediate
- in_use_imm  in  1  operand B = immediate instead of rs2
- in_rs1_en  in  1  rs1 used
- in_rs1  in  5  rs1 index
- in_rs2_en  in  1  rs2 used
- in_rs2  in  5  rs2 index
- in_rd_en  in  1  instruction writes rd
- in_rd  in  5  rd index
- rf_r0_valid  out  1  read port 0 enable
- rf_r0_ad  out  5  read port 0 address
- rf_r1_valid  out  1  read port 1 enable
- rf_r1_ad  out  5  read port 1 address
- rf_r0_data  in  XLEN  read port 0 data
- rf_r1_data  in  XLEN  read port 1 data
- rf_r_v  in  1  all requested operands not busy
- rf_block_rd  out  1  mark rd busy (one-cycle pulse)
- rf_rd  out  5  rd index to mark busy
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op  out  OPW  registered opcode
- out_pc  out  XLEN  registered PC
- out_a  out  XLEN  operand A
- out_b  out  XLEN  operand B
- out_rd_en  out  1  registered rd enable
- out_rd  out  5  registered rd
- stall_cnt  out  32  saturating count of cycles held instruction waited on rf_r_v=0

Behaviour:
- Reset is asynchronous. All outputs and state are 0, including out_*, stall_cnt, rf_block_rd and the hold register. FSM resets to IDLE.
- FSM states:
  - IDLE: hold register empty; in_ready=1.
  - WAIT: hold register full.
- Accept condition: in_valid & in_ready. Fields are latched into the hold register, FSM goes to WAIT. Nothing is issued in the accept cycle (minimum latency is 2 cycles from accept to out_valid).
- In WAIT, read ports are driven combinationally from the hold register:
  - rf_r0_valid = rs1_en, rf_r0_ad = rs1.
  - rf_r1_valid = rs2_en & ~use_imm, rf_r1_ad = rs2.
- The read ports are 0 in IDLE.
- slot_free = ~out_valid | out_ready.
- issue = WAIT & rf_r_v & slot_free & ~flush.
- On issue, the output register captures:
  - op, pc, rd_en, rd.
  - out_a = rs1_en ? (rs1==0 ? 0 : rf_r0_data) : 0.
  - out_b = use_imm ? imm : (rs2_en ? (rs2==0 ? 0 : rf_r1_data) : 0).
  - out_valid is set to 1.
- rf_block_rd = issue & rd_en & (rd!=0), combinational in the issue cycle. rf_rd = held rd.
- in_ready = IDLE | issue. If issue & in_valid, the new instruction loads and the FSM stays in WAIT (back-to-back throughput 1/cycle).
- A back-to-back dependent instruction sees rf_r_v=0 from the register file's busy bit and waits.
- If out_valid & out_ready & ~issue, out_valid clears next cycle.
- Output fields are stable while out_valid=1 and out_ready=0.
- stall_cnt increments when WAIT & ~rf_r_v & ~flush, and saturates at 0xFFFFFFFF. A slot-full stall does not count.
- flush (highest priority):
  - Next cycle: FSM to IDLE, out_valid=0, hold register cleared.
  - In the flush cycle: in_ready=0 and rf_block_rd=0.
  - stall_cnt is retained.
- Reset asserted mid-WAIT drops the held instruction; no block_rd pulse is emitted.

Test Plan:
- Reset, then in: rs1=1, rs2=2, rd=3, with rf_r_v=1, rf data 0x11/0x22 -> 2 cycles after accept: out_valid=1, out_a=0x11, out_b=0x22; rf_block_rd pulses once with rf_rd=3.
- rs1=0 with rf_r0_data=0xDEAD; use_imm=1, imm=0x7 -> out_a=0, out_b=0x7; rf_r1_valid=0; rd=0 gives no block_rd.
- Hold rf_r_v=0 for 5 cycles in WAIT -> out_valid stays 0, stall_cnt=5, in_ready=0; release -> issue next cycle.
- out_ready=0 for 3 cycles with two queued instructions -> first stays stable on out_*, second waits in hold, no block_rd for second until slot frees, stall_cnt unchanged.
- Stream 4 independent instructions with in_valid=1, out_ready=1, rf_r_v=1 -> 4 consecutive out_valid cycles, PCs in order.
- Assert flush while WAIT and out_valid=1 -> next cycle out_valid=0, in_ready=1, no block_rd in the flush cycle; async rst mid-WAIT -> all outputs 0 immediately.
